// File: rtl/button_event_pkg.sv
// Shared operate codes, default button-to-code table and default debounce length
// for the button event encoder.
package button_event_pkg;

   localparam logic [7:0] OP_MOVE     = 8'h4d;
   localparam logic [7:0] OP_THROW    = 8'h54;
   localparam logic [7:0] OP_GET      = 8'h47;
   localparam logic [7:0] OP_INTERACT = 8'h49;
   localparam logic [7:0] OP_PUT      = 8'h50;
   localparam logic [7:0] OP_IGNORE   = 8'h00;

   localparam int DEBOUNCE_CNT_DEFAULT = 1_000_000;

   // byte i = code of button i; order up, down, center, left, right
   localparam logic [39:0] OPCODE_TABLE_DEFAULT = {OP_PUT, OP_GET, OP_INTERACT, OP_THROW, OP_MOVE};

endpackage

// File: rtl/button_event_encoder_if.sv
// Valid/ready event stream from the button encoder to the UART transmit path.
interface button_event_encoder_if;

   logic [7:0] data_operate;
   logic       operate_valid;
   logic       operate_ready;

   modport master (output data_operate, output operate_valid, input operate_ready);
   modport slave  (input data_operate, input operate_valid, output operate_ready);

endinterface

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser followed by a stable-run counter that toggles the
// debounced level after DEBOUNCE_CNT consecutive disagreeing samples.
module button_debounce
   import button_event_pkg::*;
#(
   parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
   parameter int CNT_W        = 21
) (
   input  logic uart_clk,
   input  logic rst_n,
   input  logic raw,
   output logic deb
);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge uart_clk) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         deb    <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (sync_b == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/button_event_encoder.sv
// Debounced push-buttons to queued 8-bit operate codes over valid/ready, plus a level
// "held" code. Define BUTTON_EVENT_AUTO_REPEAT_EN to add hold-to-repeat events.
module button_event_encoder
   import button_event_pkg::*;
#(
   parameter int                       NUM_BUTTONS  = 5,
   parameter int                       DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
   parameter int                       CNT_W        = 21,
   parameter int                       FIFO_DEPTH   = 4,
   parameter logic [NUM_BUTTONS*8-1:0] OPCODE_TABLE = OPCODE_TABLE_DEFAULT,
   parameter logic [7:0]               IGNORE_CODE  = OP_IGNORE
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   ,
   parameter int                       REPEAT_DELAY  = 25_000_000,
   parameter int                       REPEAT_PERIOD = 5_000_000
`endif
) (
   input  logic                          uart_clk,
   input  logic                          rst_n,
   input  logic [NUM_BUTTONS-1:0]        buttons_raw,
   button_event_encoder_if.master        op,
   output logic [7:0]                    held_operate,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [NUM_BUTTONS-1:0] deb;
   logic [NUM_BUTTONS-1:0] deb_prev;
   logic                   deb_onehot;
   logic [7:0]             deb_code;
   logic                   press_evt;
   logic                   push;

   logic [7:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_nxt;
   logic [PW:0]   count;
   logic [PW:0]   cnt_nxt;
   logic [7:0]    head_nxt;
   logic          pop;
   logic          full;
   logic          do_push;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_deb
      button_debounce #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT),
         .CNT_W        (CNT_W)
      ) u_deb (
         .uart_clk (uart_clk),
         .rst_n    (rst_n),
         .raw      (buttons_raw[g]),
         .deb      (deb[g])
      );
   end

   assign deb_onehot = (deb != '0) && ((deb & (deb - NUM_BUTTONS'(1))) == '0);

   always_comb begin
      deb_code = IGNORE_CODE;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (deb[i]) deb_code = OPCODE_TABLE[8*i +: 8];
      end
   end

   // a rise only counts when it leaves exactly one button held
   assign press_evt = deb_onehot && ((deb & ~deb_prev) != '0);

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

   logic [RW-1:0] rpt_cnt;
   logic          rpt_armed;
   logic          rpt_evt;

   assign rpt_evt = rpt_armed && (deb == deb_prev) && (rpt_cnt == '0);

   // any change of the held set restarts timing; only a press arms it
   always_ff @(posedge uart_clk) begin
      if (!rst_n) begin
         rpt_armed <= 1'b0;
         rpt_cnt   <= '0;
      end else if (deb != deb_prev) begin
         rpt_armed <= press_evt;
         rpt_cnt   <= RW'(REPEAT_DELAY - 1);
      end else if (rpt_armed) begin
         rpt_cnt <= (rpt_cnt == '0) ? RW'(REPEAT_PERIOD - 1) : rpt_cnt - RW'(1);
      end
   end

   assign push = press_evt | rpt_evt;
`else
   assign push = press_evt;
`endif

   assign pop     = op.operate_valid & op.operate_ready;
   assign full    = (count == (PW+1)'(FIFO_DEPTH));
   assign do_push = push & (~full | pop);

   // next-state head so the handshake outputs can be registered
   always_comb begin
      rd_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
      cnt_nxt = count;
      if (do_push && !pop) cnt_nxt = count + (PW+1)'(1);
      else if (!do_push && pop) cnt_nxt = count - (PW+1)'(1);
      head_nxt = (do_push && (wr_ptr == rd_nxt)) ? deb_code : mem[rd_nxt];
   end

   always_ff @(posedge uart_clk) begin
      if (do_push) mem[wr_ptr] <= deb_code;
   end

   always_ff @(posedge uart_clk) begin
      if (!rst_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         overflow         <= 1'b0;
         op.operate_valid <= 1'b0;
         op.data_operate  <= IGNORE_CODE;
         held_operate     <= IGNORE_CODE;
         deb_prev         <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (push && !do_push) overflow <= 1'b1;
         rd_ptr           <= rd_nxt;
         count            <= cnt_nxt;
         op.operate_valid <= (cnt_nxt != '0);
         op.data_operate  <= (cnt_nxt != '0) ? head_nxt : IGNORE_CODE;
         held_operate     <= deb_onehot ? deb_code : IGNORE_CODE;
         deb_prev         <= deb;
      end
   end

   assign fifo_count = count;

endmodule

// File: tb/tb_button_event_encoder.sv
// Bench for button_event_encoder: directed scenarios plus random presses and ready,
// every cycle compared against a window/queue reference model.
`timescale 1ns/1ps
module tb_button_event_encoder;

   localparam int          NB  = 5;
   localparam int          DB  = 4;
   localparam int          FD  = 4;
   localparam logic [39:0] TBL = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   localparam int RD = 10;
   localparam int RP = 5;
   localparam int PRESS20_EVENTS = 3;
`else
   localparam int PRESS20_EVENTS = 1;
`endif

   logic          uart_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NB-1:0] buttons_raw = '0;
   logic [7:0]    held_operate;
   logic [2:0]    fifo_count;
   logic          overflow;

   button_event_encoder_if op();

   button_event_encoder #(
      .NUM_BUTTONS  (NB),
      .DEBOUNCE_CNT (DB),
      .CNT_W        (3),
      .FIFO_DEPTH   (FD),
      .OPCODE_TABLE (TBL),
      .IGNORE_CODE  (8'h00)
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
`endif
   ) dut (
      .uart_clk     (uart_clk),
      .rst_n        (rst_n),
      .buttons_raw  (buttons_raw),
      .op           (op),
      .held_operate (held_operate),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   always #5 uart_clk = ~uart_clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge uart_clk);
   endtask

   // reference model: debounced level flips once the last DB synchronised samples
   // all disagree with it; events and queue kept as plain SV queues
   logic [NB-1:0] hist[$];
   logic [NB-1:0] md1 = '0;
   logic [NB-1:0] md2 = '0;
   logic [7:0]    mq[$];
   logic          m_ovf = 1'b0;
   logic [7:0]    m_held = 8'h00;
   int            cyc = 0;
   logic          checking = 1'b0;
   logic [7:0]    got[$];
   int            got_t[$];
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   logic          m_armed = 1'b0;
   int            t_press = 0;
`endif

   always @(posedge uart_clk) begin
      logic [7:0]    code;
      logic          ev;
      logic          rpt;
      logic [NB-1:0] tog;
      cyc++;
      if (!rst_n) begin
         hist = {};
         for (int i = 0; i < 2 + DB; i++) hist.push_back('0);
         md1 = '0;
         md2 = '0;
         mq = {};
         m_ovf = 1'b0;
         m_held = 8'h00;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
         m_armed = 1'b0;
`endif
      end else begin
         code = 8'h00;
         for (int i = 0; i < NB; i++) if (md1[i]) code = TBL[8*i +: 8];
         ev  = ($countones(md1) == 1) && ((md1 & ~md2) != '0);
         rpt = 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
         if (ev) begin
            m_armed = 1'b1;
            t_press = cyc;
         end else if (md1 != md2) begin
            m_armed = 1'b0;
         end else if (m_armed && (cyc - t_press >= RD) && ((cyc - t_press - RD) % RP == 0)) begin
            rpt = 1'b1;
         end
`endif
         if (op.operate_ready && mq.size() > 0) void'(mq.pop_front());
         if (ev || rpt) begin
            if (mq.size() < FD) mq.push_back(code);
            else m_ovf = 1'b1;
         end
         m_held = ($countones(md1) == 1) ? code : 8'h00;
         hist.push_back(buttons_raw);
         if (hist.size() > 2 + DB) void'(hist.pop_front());
         for (int b = 0; b < NB; b++) begin
            tog[b] = 1'b1;
            for (int j = 2; j < 2 + DB; j++)
               if (hist[hist.size() - 1 - j][b] == md1[b]) tog[b] = 1'b0;
         end
         md2 = md1;
         md1 = md1 ^ tog;
      end
   end

   always @(negedge uart_clk) begin
      if (checking) begin
         check("valid", op.operate_valid, mq.size() != 0);
         check("data", op.data_operate, (mq.size() != 0) ? mq[0] : 8'h00);
         check("count", fifo_count, mq.size());
         check("held", held_operate, m_held);
         check("overflow", overflow, m_ovf);
         if (op.operate_valid && op.operate_ready) begin
            got.push_back(op.data_operate);
            got_t.push_back(cyc);
         end
      end
   end

   task automatic press_latency(input string tag);
      int lat;
      lat = 0;
      while (!op.operate_valid && lat < 20) begin
         tick(1);
         lat++;
      end
      check(tag, lat, 7);
   endtask

   initial begin
      op.operate_ready = 1'b0;
      tick(2);
      checking = 1'b1;
      check("rst_valid", op.operate_valid, 0);
      check("rst_data", op.data_operate, 8'h00);
      check("rst_count", fifo_count, 0);
      check("rst_held", held_operate, 8'h00);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      tick(3);

      // clean press of button 2
      op.operate_ready = 1'b1;
      got = {};
      buttons_raw[2] = 1'b1;
      press_latency("press_latency");
      tick(10);
      check("press_held", held_operate, 8'h03);
      buttons_raw[2] = 1'b0;
      tick(20);
      check("press_events", got.size(), PRESS20_EVENTS);
      check("press_code", got[0], 8'h03);

      // bounce on button 0, then a steady hold
      got = {};
      for (int k = 0; k < 6; k++) begin
         buttons_raw[0] = ~buttons_raw[0];
         tick(2);
      end
      buttons_raw[0] = 1'b1;
      press_latency("bounce_latency");
      tick(13);
      buttons_raw[0] = 1'b0;
      tick(20);
      check("bounce_events", got.size(), PRESS20_EVENTS);
      check("bounce_code", got[0], 8'h01);

      // chord 1+3, then release 3
      got = {};
      buttons_raw = 5'b01010;
      tick(20);
      check("chord_held", held_operate, 8'h00);
      buttons_raw[3] = 1'b0;
      tick(20);
      check("chord_held_after", held_operate, 8'h02);
      buttons_raw = '0;
      tick(15);
      check("chord_events", got.size(), 0);

      // backpressure and overflow
      op.operate_ready = 1'b0;
      got = {};
      for (int b = 0; b < NB; b++) begin
         buttons_raw[b] = 1'b1;
         tick(10);
         buttons_raw[b] = 1'b0;
         tick(10);
      end
      check("ovf_count", fifo_count, 4);
      check("ovf_flag", overflow, 1);
      op.operate_ready = 1'b1;
      tick(8);
      check("drain_n", got.size(), 4);
      for (int k = 0; k < 4; k++) check("drain_code", got[k], k + 1);
      check("drain_valid", op.operate_valid, 0);
      check("drain_data", op.data_operate, 8'h00);

      // reset with two queued entries and a debounce in flight
      op.operate_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         buttons_raw[b] = 1'b1;
         tick(10);
         buttons_raw[b] = 1'b0;
         tick(10);
      end
      check("pre_rst_count", fifo_count, 2);
      buttons_raw[2] = 1'b1;
      tick(4);
      buttons_raw = '0;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("mid_rst_valid", op.operate_valid, 0);
      check("mid_rst_data", op.data_operate, 8'h00);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_held", held_operate, 8'h00);
      check("mid_rst_ovf", overflow, 0);
      got = {};
      op.operate_ready = 1'b1;
      tick(15);
      check("mid_rst_events", got.size(), 0);

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
      // hold-to-repeat on button 4; deb falls 28 cycles after the press event
      got = {};
      got_t = {};
      buttons_raw[4] = 1'b1;
      tick(28);
      buttons_raw[4] = 1'b0;
      tick(20);
      check("rpt_events", got.size(), 5);
      for (int k = 0; k < 5; k++) check("rpt_code", got[k], 8'h05);
      check("rpt_first", got_t[1] - got_t[0], 10);
      for (int k = 2; k < 5; k++) check("rpt_period", got_t[k] - got_t[k-1], 5);
`endif

      // random presses and backpressure, model-checked every cycle
      for (int k = 0; k < 80; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 5) buttons_raw = NB'(1 << $urandom_range(0, NB - 1));
         else if (r < 8) buttons_raw = '0;
         else buttons_raw = NB'($urandom);
         op.operate_ready = ($urandom_range(0, 3) != 0);
         tick($urandom_range(1, 12));
      end
      buttons_raw = '0;
      op.operate_ready = 1'b1;
      tick(20);
      check("final_valid", op.operate_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_event_encoder.md
Name: button_event_encoder

Overview:
Parametrised successor to the five-button traveler operate encoder.
- Debounces NUM_BUTTONS raw push-buttons independently.
- Turns each clean single-button press into one 8-bit operate code.
- Queues the codes in a small FIFO and presents them to the UART transmit path over a valid/ready handshake, so no press is lost while the UART is busy.
- Also provides a level "currently held" code for consumers that sample continuously.

Parameters:
NUM_BUTTONS, 5, number of button inputs (1..16)
DEBOUNCE_CNT, 1_000_000, consecutive stable cycles required before a debounced state changes (>=1)
CNT_W, 21, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CNT
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)
OPCODE_TABLE, package default, NUM_BUTTONS*8-bit flat vector; byte i is the code for button i
IGNORE_CODE, 8'h00, code driven when nothing is valid or held

Ports:
uart_clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
buttons_raw  in  NUM_BUTTONS  asynchronous raw button levels, 1 = pressed
data_operate  out  8  head-of-queue code; IGNORE_CODE when queue empty
operate_valid  out  1  queue non-empty
operate_ready  in  1  consumer accepts head when valid&ready
held_operate  out  8  code of the single debounced-held button, else IGNORE_CODE
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky; set when an event is dropped because the queue is full

Behaviour:
- Reset is synchronous: on any uart_clk edge with rst_n=0, all of the following are cleared, including mid-debounce or mid-handshake:
  - synchronisers, debounced states and counters to 0
  - queue emptied
  - data_operate=IGNORE_CODE, operate_valid=0, held_operate=IGNORE_CODE, fifo_count=0, overflow=0
  - any repeat timer (optional feature)
- Synchronisation: 2-FF synchroniser per button, 2-cycle latency before the debouncer sees a change.
- Debounce, per button:
  - sync==deb: counter is reset to 0.
  - sync!=deb: counter increments.
  - When the counter reaches DEBOUNCE_CNT-1 while still different, deb toggles on that edge and the counter clears.
  - Any glitch back to deb restarts the count.
- Press event: a button's deb rises 0->1 and the updated deb vector has exactly one bit set. The event is enqueued on the same edge, carrying OPCODE_TABLE byte i.
  - Chords (more than one deb high) produce no event.
  - Two rising edges in the same cycle produce no event.
  - Releases produce no event.
- Queue:
  - Pop on operate_valid & operate_ready.
  - Push on event; if full and not popping, the event is dropped and overflow set.
  - Simultaneous push and pop when full: both succeed and count is unchanged.
  - Simultaneous push and pop when empty: the push succeeds, no pop occurs, and valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Output timing: data_operate/operate_valid are registered; a press is visible 1 cycle after the debounce toggle edge.
- held_operate: registered. Equals the code of button i when deb is one-hot at bit i, otherwise IGNORE_CODE. This gives the legacy level behaviour.

Optional Feature:
Macro: BUTTON_EVENT_AUTO_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 25_000_000) and REPEAT_PERIOD (default 5_000_000).
  - While the same single button stays debounced-held, a repeat event with the same code is enqueued REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles.
  - Any change in the deb vector cancels and restarts timing.
  - Repeats obey the full/overflow rules above.
- Undefined: no repeat logic, and exactly one event per press.

Decomposition:
- Shared package button_event_pkg holds:
  - the operate code constants (MOVE, THROW, GET, INTERACT, PUT, IGNORE)
  - the default 5-button OPCODE_TABLE, with button order up, down, center, left, right
  - the default DEBOUNCE_CNT
- One natural sub-module: button_debounce, a single-bit synchroniser plus counter, instantiated NUM_BUTTONS times with a generate loop.
- The queue stays inline.

Test Plan:
Common settings: NUM_BUTTONS=5, DEBOUNCE_CNT=4, FIFO_DEPTH=4, OPCODE_TABLE bytes 0..4 = 8'h01,8'h02,8'h03,8'h04,8'h05.
- Clean press: hold button 2 for 20 cycles, operate_ready=1.
  - Required: one valid cycle with data_operate=8'h03 at 2+4+1 cycles after the input edge.
  - Required: held_operate=8'h03 while held.
  - Required: nothing on release.
- Bounce: toggle button 0 every 2 cycles for 12 cycles, then hold.
  - Required: exactly one 8'h01 event, timed 4 debounced cycles after the final stable edge.
- Chord: assert buttons 1 and 3 on the same cycle.
  - Required: no event, held_operate=8'h00.
  - Required: after releasing 3, still no event, because 1 did not rise.
- Backpressure/overflow: operate_ready=0, with 5 separate presses of buttons 0,1,2,3,4.
  - Required: fifo_count=4, and overflow=1 after the fifth press.
  - Then raise ready: the bench must see 01,02,03,04 in order, then valid=0 and data_operate=8'h00.
- Reset mid-operation: with the queue holding 2 entries and a debounce in progress, pull rst_n low for 1 cycle.
  - Required: on the next cycle all outputs are at reset values, with no event from the interrupted debounce.
- With BUTTON_EVENT_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold button 4 for 30 cycles after debounce.
  - Required: events 8'h05 at +0, +10, +15, +20, +25.
